// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU constants: md_op encoding used by both the hazard unit and the
// controller, default latencies, and the controller state type.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: computes results on start, holds them in a
// pending register for a fixed latency, then commits to the HI/LO registers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no operation in flight; accepts start, mthi/mtlo write now
// ST_MUL  | mult/multu in flight; cnt counts down to commit
// ST_DIV  | div/divu in flight; cnt counts down to commit (or no-op if /0)
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_instD,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e       state, stateN;
  logic [CNT_W-1:0] cnt, cntN;
  logic [63:0]      pend, pendN;
  logic             pendWr, pendWrN;
  logic [31:0]      hiN, loN;

  logic signed [63:0] prodS;
  logic [63:0]        prodU;
  logic [31:0]        absA, absB, divB, quoMag, remMag, quoS, remS, quoU, remU;

  always_comb begin
    prodS = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prodU = {32'd0, a} * {32'd0, b};

    // Divisor forced non-zero so the dividers never see /0; the result is
    // discarded in that case anyway.
    divB   = (b == 32'd0) ? 32'd1 : b;
    quoU   = a / divB;
    remU   = a % divB;

    // Signed divide on magnitudes: truncation toward zero falls out directly,
    // and 0x80000000 / -1 wraps back to 0x80000000 without overflow.
    absA   = a[31] ? (~a + 32'd1) : a;
    absB   = divB[31] ? (~divB + 32'd1) : divB;
    quoMag = absA / absB;
    remMag = absA % absB;
    quoS   = (a[31] ^ divB[31]) ? (~quoMag + 32'd1) : quoMag;
    remS   = a[31] ? (~remMag + 32'd1) : remMag;
  end

  always_comb begin
    stateN  = state;
    cntN    = cnt;
    pendN   = pend;
    pendWrN = pendWr;
    hiN     = hi;
    loN     = lo;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT: begin
              pendN   = prodS;
              pendWrN = 1'b1;
              cntN    = CNT_W'(MULT_LAT);
              stateN  = ST_MUL;
            end
            MD_MULTU: begin
              pendN   = prodU;
              pendWrN = 1'b1;
              cntN    = CNT_W'(MULT_LAT);
              stateN  = ST_MUL;
            end
            MD_DIV: begin
              pendN   = {remS, quoS};
              pendWrN = (b != 32'd0);
              cntN    = CNT_W'(DIV_LAT);
              stateN  = ST_DIV;
            end
            MD_DIVU: begin
              pendN   = {remU, quoU};
              pendWrN = (b != 32'd0);
              cntN    = CNT_W'(DIV_LAT);
              stateN  = ST_DIV;
            end
            MD_MTHI: hiN = a;
            MD_MTLO: loN = a;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        cntN = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          cntN   = '0;
          stateN = ST_IDLE;
          if (pendWr) begin
            hiN = pend[63:32];
            loN = pend[31:0];
          end
        end
      end
      default: stateN = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      pend   <= '0;
      pendWr <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= stateN;
      cnt    <= cntN;
      busy   <= (stateN != ST_IDLE);
      pend   <= pendN;
      pendWr <= pendWrN;
      hi     <= hiN;
      lo     <= loN;
    end
  end

  assign stall = md_instD & (busy | start);

  always_comb begin
    rdata = 32'd0;
    if (md_op == MD_MFHI) rdata = hi;
    else if (md_op == MD_MFLO) rdata = lo;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5: busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_LAT, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage pulse: the instruction in E is an MDU operation.
REQ-006 SHALL have port md_op  input  4  E-stage MDU opcode (encoding per REQ-031).
REQ-007 SHALL have port a  input  32  forwarded rs operand.
REQ-008 SHALL have port b  input  32  forwarded rt operand.
REQ-009 SHALL have port md_instD  input  1  D-stage instruction is any MDU-class instruction.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port stall  output  1  stall request to the hazard unit (freeze F/D, bubble E).
REQ-012 SHALL have port hi  output  32  architectural HI register.
REQ-013 SHALL have port lo  output  32  architectural LO register.
REQ-014 SHALL have port rdata  output  32  mfhi/mflo read value for the E-stage result mux.

Function
REQ-015 SHALL implement FSM states IDLE, MUL and DIV, plus a down-counter cnt.
REQ-016 IDLE with start=1 and md_op in {mult, multu}: SHALL latch the 64-bit product into a pending register, load cnt=MULT_LAT and go to MUL.
REQ-017 IDLE with start=1 and md_op in {div, divu}: SHALL latch quotient/remainder into the pending register, load cnt=DIV_LAT and go to DIV.
REQ-018 In MUL/DIV, cnt SHALL decrement each cycle; at the edge where cnt==1, pending SHALL be written to hi/lo and the FSM SHALL return to IDLE.
REQ-019 Timing: start sampled at edge t; busy=1 for cycles t+1..t+LAT; new hi/lo visible from t+LAT+1 with busy=0.
REQ-020 busy SHALL be registered: 1 exactly when state!=IDLE.
REQ-021 stall SHALL equal md_instD & (busy | start), combinationally.
REQ-022 Signed mult: {hi,lo} = signed a * signed b. Unsigned mult: zero-extended product.
REQ-023 Division: lo=quotient, hi=remainder. Signed division truncates toward zero, and the remainder takes the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0.
REQ-024 Divide by zero SHALL still hold busy for DIV_LAT cycles and SHALL leave hi/lo unchanged.
REQ-025 mthi/mtlo with start=1 in IDLE SHALL write a to hi/lo at the next edge, with no busy.
REQ-026 rdata SHALL be hi when md_op=mfhi, lo when md_op=mflo, otherwise 0; combinational from current hi/lo.
REQ-027 start while busy SHALL be ignored: no state change and no hi/lo write.
REQ-028 md_op values outside the defined set SHALL be treated as none.

Reset
REQ-029 reset SHALL asynchronously force state=IDLE, cnt=0, busy=0, hi=0, lo=0 and pending=0.
REQ-030 reset asserted mid-operation SHALL abort the operation; hi/lo stay 0 after release, and busy=0 on the first cycle after release.

Structure
REQ-031 The md_op encoding SHALL be defined in constants.vh: none=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8. The hazard unit and controller SHALL share it.
REQ-032 MULT_LAT and DIV_LAT defaults SHALL also be defined in constants.vh.
REQ-033 The block SHALL have no sub-module; the arithmetic is inline, with the FSM and counter in one module.

Verification
REQ-034 mult with a=0xFFFFFFFE, b=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 divu with a=7, b=2 -> busy high for 10 cycles, then hi=1, lo=3; div with a=-7, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-036 div with b=0 after mthi 0x11 and mtlo 0x22 -> busy high for 10 cycles; hi=0x11, lo=0x22 unchanged.
REQ-037 start mult with md_instD=1 on the same and following cycles -> stall=1 on the start cycle and all 5 busy cycles, then 0; mflo rdata returns the new lo.
REQ-038 Second start during busy -> ignored; reset pulse at busy cycle 3 -> busy=0, hi=lo=0 immediately, with no late write.
